// File: rtl/debouncer_mc.sv
// Multi-channel pushbutton/switch debouncer: 2-flop sync, symmetric 2^N-sample filter, level + event pulses.
// Define DEBOUNCE_LONGPRESS_EN to add per-channel long-press detection on long_pulse.
module debouncer_mc #(
  parameter int unsigned     CH      = 4,
  parameter int unsigned     N       = 20,
  parameter logic [CH-1:0]   ACT_LOW = {CH{1'b1}},
  parameter int unsigned     LONG_W  = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] noisy_in,
  output logic [CH-1:0] clean_out,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] release_pulse,
  output logic [CH-1:0] long_pulse,
  output logic          any_active
);

  localparam logic [N-1:0] CNT_MAX = '1;

  logic [CH-1:0]        sync1_q, sync1_d;
  logic [CH-1:0]        sync2_q, sync2_d;
  logic [CH-1:0]        st_q, st_d;
  logic [CH-1:0][N-1:0] cnt_q, cnt_d;
  logic [CH-1:0]        press_q, press_d;
  logic [CH-1:0]        release_q, release_d;
  logic                 any_q, any_d;

  always_comb begin
    sync1_d   = noisy_in ^ ACT_LOW;
    sync2_d   = sync1_q;
    st_d      = st_q;
    cnt_d     = '0;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      // Any sample agreeing with the current level leaves cnt_d at zero, restarting the filter.
      if (sync2_q[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          st_d[i]      = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |st_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      st_q      <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign clean_out     = st_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_active    = any_q;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [LONG_W-1:0] HOLD_MAX = '1;
  localparam logic [LONG_W-1:0] HOLD_PRE = HOLD_MAX - 1'b1;

  logic [CH-1:0][LONG_W-1:0] hold_q, hold_d;
  logic [CH-1:0]             long_q, long_d;

  always_comb begin
    hold_d = '0;
    long_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (st_q[i]) begin
        hold_d[i] = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
        // Saturation makes the pre-max value occur once per press, so the pulse cannot repeat.
        long_d[i] = (hold_q[i] == HOLD_PRE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = '0;
`endif

endmodule

// File: tb/tb_debouncer_mc.sv
// Scoreboard bench for debouncer_mc: a run-length reference model queues expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_debouncer_mc;

  localparam int CH     = 2;
  localparam int N      = 4;
  localparam int LONG_W = 6;
  localparam logic [CH-1:0] ACT_LOW = 2'b11;
  localparam int FILT = 1 << N;
  localparam int LONG = (1 << LONG_W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy_in;
  logic [CH-1:0] clean_out, press_pulse, release_pulse, long_pulse;
  logic          any_active;

  debouncer_mc #(
    .CH      (CH),
    .N       (N),
    .ACT_LOW (ACT_LOW),
    .LONG_W  (LONG_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .noisy_in      (noisy_in),
    .clean_out     (clean_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .any_active    (any_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] clean;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] lng;
    logic          any;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   drive_done  = 1'b0;
  bit   mon_done    = 1'b0;

  // Reference model: pressed level per channel, length of the current run of
  // samples disagreeing with it, and edges spent pressed.
  logic [CH-1:0] m_st;
  int            m_run[CH];
  int            m_age[CH];
  logic [CH-1:0] m_hist[$];

  task automatic apply(input logic r, input logic [CH-1:0] v);
    exp_t          e;
    logic [CH-1:0] seen;
    reset    = r;
    noisy_in = v;
    e        = '0;
    if (r) begin
      m_st = '0;
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
      m_hist.delete();
      m_hist.push_back('0);
      m_hist.push_back('0);
    end else begin
      m_hist.push_back(v ^ ACT_LOW);
      seen = m_hist.pop_front();
      for (int i = 0; i < CH; i++) begin
        if (m_st[i]) begin
          if (m_age[i] < LONG) begin
            m_age[i]++;
            if (m_age[i] == LONG) e.lng[i] = 1'b1;
          end
        end else begin
          m_age[i] = 0;
        end
        if (seen[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == FILT) begin
            m_st[i] = seen[i];
            if (seen[i]) e.press[i] = 1'b1;
            else         e.rel[i]   = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
`ifndef DEBOUNCE_LONGPRESS_EN
    e.lng = '0;
`endif
    e.clean = m_st;
    e.any   = |m_st;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold_for(input logic r, input logic [CH-1:0] v, input int n);
    for (int k = 0; k < n; k++) apply(r, v);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (drive_done) break;
        continue;
      end
      e = exp_q.pop_front();
      vectors++;
      if (clean_out !== e.clean || press_pulse !== e.press || release_pulse !== e.rel ||
          long_pulse !== e.lng || any_active !== e.any) begin
        miscompares++;
        $display("FAIL vec %0d @%0t: clean=%b/%b press=%b/%b release=%b/%b long=%b/%b any=%b/%b (got/expected)",
                 vectors, $time, clean_out, e.clean, press_pulse, e.press, release_pulse, e.rel,
                 long_pulse, e.lng, any_active, e.any);
      end
    end
    mon_done = 1'b1;
  end

  initial begin : stimulus
    logic [CH-1:0] cur;
    int            left[CH];
    reset    = 1'b1;
    noisy_in = '1;
    // Idle after reset: nothing may assert.
    hold_for(1'b1, 2'b11, 5);
    hold_for(1'b0, 2'b11, 100);
    // Channel 0 press, then release.
    hold_for(1'b0, 2'b10, 40);
    hold_for(1'b0, 2'b11, 30);
    // Bounce during press restarts the filter.
    hold_for(1'b0, 2'b10, 10);
    hold_for(1'b0, 2'b11, 1);
    hold_for(1'b0, 2'b10, 30);
    hold_for(1'b0, 2'b11, 30);
    // Both channels together, held long enough for the long-press pulse.
    hold_for(1'b0, 2'b00, 100);
    // Reset while pressed, input kept active: fresh press afterwards.
    hold_for(1'b1, 2'b00, 1);
    hold_for(1'b0, 2'b00, 30);
    hold_for(1'b0, 2'b11, 30);
    // Random segments of bounce and stable levels, rare resets.
    cur = '1;
    for (int i = 0; i < CH; i++) left[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < CH; i++) begin
        if (left[i] == 0) begin
          cur[i]  = 1'($urandom_range(0, 1));
          left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                : int'($urandom_range(10, 90));
        end
        left[i]--;
      end
      apply(($urandom_range(0, 299) == 0), cur);
    end
    drive_done = 1'b1;
    for (int k = 0; k < 100 && !mon_done; k++) @(posedge clk);
    #2;
    if (!mon_done) begin
      miscompares++;
      $display("FAIL monitor_timeout: pending=%0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
